// File: rtl/gate_bist.sv
// Self-test sequencer for the Nand/Not/And/Or/Xor/Mux/DMux gate bank.
// Sweeps {in,a,b,sel} over 16 vectors, compares responses to golden values, latches results.
module gate_bist #(
    parameter int unsigned SETTLE       = 1,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    output logic       t_in_o,
    output logic       t_a_o,
    output logic       t_b_o,
    output logic       t_sel_o,
    input  logic       r_nand_i,
    input  logic       r_not_i,
    input  logic       r_and_i,
    input  logic       r_or_i,
    input  logic       r_xor_i,
    input  logic       r_mux_i,
    input  logic       r_dmux_a_i,
    input  logic       r_dmux_b_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] fail_vec_o,
    output logic [7:0] fail_mask_o,
    output logic [4:0] fail_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t     state_q;
    logic [3:0] v_q;
    logic [3:0] cnt_q;
    logic [3:0] t_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] fail_vec_q;
    logic [7:0] fail_mask_q;
    logic [4:0] fail_count_q;

    logic       v_in, v_a, v_b, v_sel;
    logic [7:0] exp_d;
    logic [7:0] resp_d;
    logic [7:0] mism_d;
    logic       bad_d;
    logic [4:0] fail_count_d;
    logic       last_d;

    always_comb begin
        v_in         = v_q[3];
        v_a          = v_q[2];
        v_b          = v_q[1];
        v_sel        = v_q[0];
        exp_d        = {~(v_a & v_b), ~v_in, v_a & v_b, v_a | v_b, v_a ^ v_b,
                        v_sel ? v_b : v_a, v_in & ~v_sel, v_in & v_sel};
        resp_d       = {r_nand_i, r_not_i, r_and_i, r_or_i, r_xor_i,
                        r_mux_i, r_dmux_a_i, r_dmux_b_i};
        mism_d       = exp_d ^ resp_d;
        bad_d        = (mism_d != 8'h00);
        fail_count_d = fail_count_q + {4'd0, bad_d};
        last_d       = (v_q == 4'hF) || (bad_d && STOP_ON_FAIL);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            v_q          <= '0;
            cnt_q        <= '0;
            t_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_vec_q   <= '0;
            fail_mask_q  <= '0;
            fail_count_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q      <= WAIT;
                        v_q          <= '0;
                        cnt_q        <= SETTLE_LD;
                        t_q          <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        fail_vec_q   <= '0;
                        fail_mask_q  <= '0;
                        fail_count_q <= '0;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // only the first failing vector is captured
                        if (bad_d && fail_count_q == 5'd0) begin
                            fail_vec_q  <= v_q;
                            fail_mask_q <= mism_d;
                        end
                        fail_count_q <= fail_count_d;
                        if (last_d) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (fail_count_d == 5'd0);
                            t_q     <= '0;
                        end else begin
                            v_q   <= v_q + 4'd1;
                            t_q   <= v_q + 4'd1;
                            cnt_q <= SETTLE_LD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign t_in_o       = t_q[3];
    assign t_a_o        = t_q[2];
    assign t_b_o        = t_q[1];
    assign t_sel_o      = t_q[0];
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign fail_vec_o   = fail_vec_q;
    assign fail_mask_o  = fail_mask_q;
    assign fail_count_o = fail_count_q;

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: three parameterisations driven by a fault-injectable gate bank model,
// expected run results queued at start and checked when done rises.
module tb_gate_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start [3];
    logic       t_in [3], t_a [3], t_b [3], t_sel [3];
    logic       busy [3], done [3], pass [3];
    logic [3:0] fvec [3];
    logic [7:0] fmask [3];
    logic [4:0] fcnt [3];
    logic [7:0] stuck0, invert;

    int checks = 0;
    int errors = 0;

    // inst 0: SETTLE=1 STOP=1, inst 1: SETTLE=1 STOP=0, inst 2: SETTLE=3 STOP=0
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic g_nand, g_not, g_and, g_or, g_xor, g_mux, g_da, g_db;
        logic [7:0] rsp;
        always_comb begin
            g_nand = !(t_a[g] && t_b[g]);
            g_not  = !t_in[g];
            g_and  = t_a[g] && t_b[g];
            g_or   = t_a[g] || t_b[g];
            g_xor  = t_a[g] != t_b[g];
            g_mux  = (t_sel[g] == 1'b1) ? t_b[g] : t_a[g];
            g_da   = (t_sel[g] == 1'b0) ? t_in[g] : 1'b0;
            g_db   = (t_sel[g] == 1'b1) ? t_in[g] : 1'b0;
            rsp = ({g_nand, g_not, g_and, g_or, g_xor, g_mux, g_da, g_db} & ~stuck0) ^ invert;
        end
        gate_bist #(
            .SETTLE      (g == 2 ? 3 : 1),
            .STOP_ON_FAIL(g == 0 ? 1'b1 : 1'b0)
        ) u_dut (
            .clk_i       (clk),
            .reset_i     (rst),
            .start_i     (start[g]),
            .t_in_o      (t_in[g]),
            .t_a_o       (t_a[g]),
            .t_b_o       (t_b[g]),
            .t_sel_o     (t_sel[g]),
            .r_nand_i    (rsp[7]),
            .r_not_i     (rsp[6]),
            .r_and_i     (rsp[5]),
            .r_or_i      (rsp[4]),
            .r_xor_i     (rsp[3]),
            .r_mux_i     (rsp[2]),
            .r_dmux_a_i  (rsp[1]),
            .r_dmux_b_i  (rsp[0]),
            .busy_o      (busy[g]),
            .done_o      (done[g]),
            .pass_o      (pass[g]),
            .fail_vec_o  (fvec[g]),
            .fail_mask_o (fmask[g]),
            .fail_count_o(fcnt[g])
        );
    end

    typedef struct {
        int         inst;
        logic [7:0] stuck0;
        logic [7:0] invert;
        int         edges;
        logic       pass;
        logic [3:0] vec;
        logic [7:0] mask;
        logic [4:0] cnt;
        bit         chk_t;
    } vec_t;

    typedef struct {
        int         edges;
        logic       pass;
        logic [3:0] vec;
        logic [7:0] mask;
        logic [4:0] cnt;
    } res_t;

    vec_t tbl [7];
    res_t sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] tvec(input int i);
        return {t_in[i], t_a[i], t_b[i], t_sel[i]};
    endfunction

    task automatic check_zero(input int i);
        check($sformatf("zero_outputs_inst%0d", i),
              {8'd0, t_in[i], t_a[i], t_b[i], t_sel[i], busy[i], done[i], pass[i],
               fvec[i], fmask[i], fcnt[i]}, 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check_zero(i);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int r, input bit do_reset, input int poke);
        vec_t row;
        res_t exp;
        int   i;
        int   n;
        int   per;
        row = tbl[r];
        i   = row.inst;
        per = (i == 2) ? 4 : 2;
        if (do_reset) apply_reset();
        stuck0 = row.stuck0;
        invert = row.invert;
        sb.push_back('{row.edges, row.pass, row.vec, row.mask, row.cnt});
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        check($sformatf("r%0d_start_state", r),
              {busy[i], done[i], pass[i], fvec[i], fmask[i], fcnt[i], tvec(i)},
              {1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 5'd0, 4'd0});
        n = 0;
        while (!done[i] && n < 200) begin
            @(negedge clk);
            n++;
            start[i] = (n == poke);
            if (row.chk_t && !done[i])
                check($sformatf("r%0d_tvec_e%0d", r, n), tvec(i), n / per);
        end
        start[i] = 1'b0;
        exp = sb.pop_front();
        if (!done[i]) begin
            checks++;
            errors++;
            $display("FAIL r%0d_timeout done never rose within %0d edges", r, n);
        end
        check($sformatf("r%0d_edges", r), n, exp.edges);
        check($sformatf("r%0d_pass", r), pass[i], exp.pass);
        check($sformatf("r%0d_fail_vec", r), fvec[i], exp.vec);
        check($sformatf("r%0d_fail_mask", r), fmask[i], exp.mask);
        check($sformatf("r%0d_fail_count", r), fcnt[i], exp.cnt);
        check($sformatf("r%0d_idle_after", r), {busy[i], tvec(i)}, 5'd0);
    endtask

    initial begin
        tbl[0] = '{0, 8'h00, 8'h00, 32, 1'b1, 4'h0, 8'h00, 5'd0,  1'b1};
        tbl[1] = '{0, 8'h08, 8'h00, 6,  1'b0, 4'h2, 8'h08, 5'd1,  1'b0};
        tbl[2] = '{1, 8'h08, 8'h00, 32, 1'b0, 4'h2, 8'h08, 5'd8,  1'b0};
        tbl[3] = '{2, 8'h00, 8'h01, 64, 1'b0, 4'h0, 8'h01, 5'd16, 1'b0};
        tbl[4] = '{2, 8'h00, 8'h00, 64, 1'b1, 4'h0, 8'h00, 5'd0,  1'b1};
        tbl[5] = '{1, 8'h00, 8'h80, 32, 1'b0, 4'h0, 8'h80, 5'd16, 1'b0};
        tbl[6] = '{0, 8'h04, 8'h00, 8,  1'b0, 4'h3, 8'h04, 5'd1,  1'b0};

        rst = 1'b0;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        stuck0 = 8'h00;
        invert = 8'h00;

        for (int r = 0; r < 7; r++) run(r, 1'b1, 0);

        // start pulse while busy must not disturb the sweep
        run(0, 1'b1, 5);

        // restart straight out of DONE after a failing run
        run(1, 1'b1, 0);
        run(0, 1'b0, 0);

        // asynchronous reset in the middle of a run
        stuck0 = 8'h00;
        invert = 8'h00;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero(0);
        @(negedge clk);
        rst = 1'b0;
        #1 check_zero(0);
        run(0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
